// File: rtl/mips_pkg.sv
// Shared constants and enums for the multi-cycle MIPS control unit.
// The MIPS_ADDI_EN macro adds the ADDIEX/ADDIWB states to ctrl_state_t.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [1:0] {
    SRCB_RT    = 2'b00,
    SRCB_FOUR  = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_IMMSH = 2'b11
  } alusrcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_t;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
`ifdef MIPS_ADDI_EN
    ,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
`endif
  } ctrl_state_t;

endpackage

// File: rtl/mips_retire_cnt.sv
// Retired-instruction counter: wraps modulo 2^CNT_W, cleared by reset.
module mips_retire_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             retire_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (retire_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetN) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath with a retire counter.
// Define MIPS_ADDI_EN to add the addi path (ADDIEX -> ADDIWB).
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [5:0]       opCode,
  input  logic             zero,
  input  logic             memReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             illegalOp,
  output logic [CNT_W-1:0] instrCount
);

  ctrl_state_t state_q, state_d;
  logic        retire;

  // The branch decision is made in the datapath from PCWriteCond and zero.
  logic zero_unused;
  assign zero_unused = zero;

  always_ff @(posedge clk) begin
    if (!resetN) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_ADD;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    illegalOp   = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (memReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMMSH;
        case (opCode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default: begin
            // PC+4 is already written, so an unknown opcode acts as a NOP.
            illegalOp = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        if (opCode == OP_LW)      state_d = S_MEMRD;
        else if (opCode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (memReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (memReady) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
`ifdef MIPS_ADDI_EN
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  mips_retire_cnt #(
    .CNT_W(CNT_W)
  ) u_retire_cnt (
    .clk     (clk),
    .resetN  (resetN),
    .retire_i(retire),
    .count_o (instrCount)
  );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle expected controls from an instruction-level model.
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 32;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RTY  = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] ADDI = 6'b001000;

  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_MEMADR = 3, PH_MEMRD = 4,
                 PH_MEMWB = 5, PH_MEMWR = 6, PH_EXEC = 7, PH_ALUWB = 8, PH_BRANCH = 9,
                 PH_JUMP = 10, PH_ADDIEX = 11, PH_ADDIWB = 12;

  typedef struct packed {
    logic       pcw, pcwc, iord, mrd, mwr, m2r, irw;
    logic [1:0] pcsrc, aluop;
    logic       srca;
    logic [1:0] srcb;
    logic       rw, rdst, ill;
  } out_t;

  typedef struct {
    out_t        o;
    int unsigned cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             resetN = 1'b0;
  logic [5:0]       opCode = '0;
  logic             zero = 1'b0;
  logic             memReady = 1'b0;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0]       PCSource, ALUOp, ALUSrcB;
  logic             ALUSrcA, RegWrite, RegDst, illegalOp;
  logic [CNT_W-1:0] instrCount;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned model_cnt = 0;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .resetN(resetN), .opCode(opCode), .zero(zero), .memReady(memReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .illegalOp(illegalOp), .instrCount(instrCount)
  );

  // Control word each phase of an instruction must present.
  function automatic out_t exp_out(input int ph, input bit rdy, input bit ill);
    out_t e;
    e = '0;
    case (ph)
      PH_FETCH:  begin e.mrd = 1'b1; e.srcb = 2'b01; e.irw = rdy; e.pcw = rdy; end
      PH_DECODE: begin e.srcb = 2'b11; e.ill = ill; end
      PH_MEMADR: begin e.srca = 1'b1; e.srcb = 2'b10; end
      PH_MEMRD:  begin e.mrd = 1'b1; e.iord = 1'b1; end
      PH_MEMWB:  begin e.rw = 1'b1; e.m2r = 1'b1; end
      PH_MEMWR:  begin e.mwr = 1'b1; e.iord = 1'b1; end
      PH_EXEC:   begin e.srca = 1'b1; e.aluop = 2'b10; end
      PH_ALUWB:  begin e.rw = 1'b1; e.rdst = 1'b1; end
      PH_BRANCH: begin e.srca = 1'b1; e.aluop = 2'b01; e.pcwc = 1'b1; e.pcsrc = 2'b01; end
      PH_JUMP:   begin e.pcw = 1'b1; e.pcsrc = 2'b10; end
      PH_ADDIEX: begin e.srca = 1'b1; e.srcb = 2'b10; end
      PH_ADDIWB: begin e.rw = 1'b1; end
      default:   e = '0;
    endcase
    return e;
  endfunction

  task automatic step(input int ph, input bit rdy, input bit rst_n, input logic [5:0] op,
                      input bit ill, input bit retire);
    exp_t x;
    @(posedge clk);
    #1;
    resetN   = rst_n;
    memReady = rdy;
    opCode   = op;
    zero     = 1'($urandom);
    x.o      = exp_out(ph, rdy, ill);
    x.cnt    = model_cnt;
    sb.push_back(x);
    if (!rst_n)      model_cnt = 0;
    else if (retire) model_cnt = model_cnt + 1;
  endtask

  task automatic fetch(input int sf);
    for (int i = 0; i < sf; i++) step(PH_FETCH, 1'b0, 1'b1, 6'($urandom), 1'b0, 1'b0);
    step(PH_FETCH, 1'b1, 1'b1, 6'($urandom), 1'b0, 1'b0);
  endtask

  task automatic run_instr(input logic [5:0] op, input int sf, input int sm);
    fetch(sf);
    case (op)
      LW: begin
        step(PH_DECODE, 1'($urandom), 1'b1, op, 1'b0, 1'b0);
        step(PH_MEMADR, 1'($urandom), 1'b1, op, 1'b0, 1'b0);
        for (int i = 0; i < sm; i++) step(PH_MEMRD, 1'b0, 1'b1, op, 1'b0, 1'b0);
        step(PH_MEMRD, 1'b1, 1'b1, op, 1'b0, 1'b0);
        step(PH_MEMWB, 1'($urandom), 1'b1, op, 1'b0, 1'b1);
      end
      SW: begin
        step(PH_DECODE, 1'($urandom), 1'b1, op, 1'b0, 1'b0);
        step(PH_MEMADR, 1'($urandom), 1'b1, op, 1'b0, 1'b0);
        for (int i = 0; i < sm; i++) step(PH_MEMWR, 1'b0, 1'b1, op, 1'b0, 1'b0);
        step(PH_MEMWR, 1'b1, 1'b1, op, 1'b0, 1'b1);
      end
      RTY: begin
        step(PH_DECODE, 1'($urandom), 1'b1, op, 1'b0, 1'b0);
        step(PH_EXEC, 1'($urandom), 1'b1, op, 1'b0, 1'b0);
        step(PH_ALUWB, 1'($urandom), 1'b1, op, 1'b0, 1'b1);
      end
      BEQ: begin
        step(PH_DECODE, 1'($urandom), 1'b1, op, 1'b0, 1'b0);
        step(PH_BRANCH, 1'($urandom), 1'b1, op, 1'b0, 1'b1);
      end
      JMP: begin
        step(PH_DECODE, 1'($urandom), 1'b1, op, 1'b0, 1'b0);
        step(PH_JUMP, 1'($urandom), 1'b1, op, 1'b0, 1'b1);
      end
`ifdef MIPS_ADDI_EN
      ADDI: begin
        step(PH_DECODE, 1'($urandom), 1'b1, op, 1'b0, 1'b0);
        step(PH_ADDIEX, 1'($urandom), 1'b1, op, 1'b0, 1'b0);
        step(PH_ADDIWB, 1'($urandom), 1'b1, op, 1'b0, 1'b1);
      end
`endif
      default: step(PH_DECODE, 1'($urandom), 1'b1, op, 1'b1, 1'b0);
    endcase
  endtask

  // Store aborted by reset while waiting on memory: no retire, counter cleared.
  task automatic sw_reset_in_memwr();
    fetch(0);
    step(PH_DECODE, 1'b1, 1'b1, SW, 1'b0, 1'b0);
    step(PH_MEMADR, 1'b1, 1'b1, SW, 1'b0, 1'b0);
    step(PH_MEMWR, 1'($urandom), 1'b0, SW, 1'b0, 1'b0);
    step(PH_IDLE, 1'($urandom), 1'b1, 6'($urandom), 1'b0, 1'b0);
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      out_t act;
      e   = sb.pop_front();
      act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, PCSource,
             ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, illegalOp};
      vectors++;
      if (act !== e.o) begin
        miscompares++;
        $display("FAIL ctrl_word t=%0t actual=%05h expected=%05h", $time, act, e.o);
      end
      vectors++;
      if (instrCount !== e.cnt) begin
        miscompares++;
        $display("FAIL instrCount t=%0t actual=%0d expected=%0d", $time, instrCount, e.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] ops[7];
    ops[0] = LW; ops[1] = SW; ops[2] = RTY; ops[3] = BEQ; ops[4] = JMP; ops[5] = ADDI;

    // Two reset edges, then release: IDLE for both cycles, FETCH follows.
    step(PH_IDLE, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0);
    step(PH_IDLE, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0);

    run_instr(LW, 0, 0);
    run_instr(SW, 0, 0);
    run_instr(RTY, 0, 0);
    run_instr(BEQ, 0, 0);
    run_instr(JMP, 0, 0);
    run_instr(LW, 3, 2);
    run_instr(6'b011001, 0, 0);
    run_instr(ADDI, 0, 0);
    sw_reset_in_memwr();

    for (int n = 0; n < 80; n++) begin
      ops[6] = 6'($urandom);
      if ($urandom_range(0, 19) == 0) sw_reset_in_memwr();
      else run_instr(ops[$urandom_range(0, 6)], $urandom_range(0, 3), $urandom_range(0, 3));
    end

    begin
      int budget;
      budget = 0;
      while (sb.size() > 0 && budget < 10) begin
        @(posedge clk);
        budget++;
      end
      if (sb.size() > 0) begin
        miscompares++;
        $display("FAIL drain pending=%0d required=0", sb.size());
      end
    end
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
